formula_2_inverse_pipe_using_fifos: RTL and testbench
=====================================================

FORMULA_2_INVERSE_PIPE_USING_FIFOS -- requirements
Module: formula_2_inverse_pipe_using_fifos

Interface
REQ-001 SHALL have parameter MUL_STAGES, default 4, register stages inside each squarer (>=1).
REQ-002 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port arg_vld  input  1  r/a/b valid this cycle; no backpressure.
REQ-005 SHALL have port r  input  16  candidate root.
REQ-006 SHALL have port a  input  32  outer addend.
REQ-007 SHALL have port b  input  32  middle addend.
REQ-008 SHALL have port res_vld  output  1  res/err valid, one pulse per accepted token.
REQ-009 SHALL have port res  output  32  reconstructed c.
REQ-010 SHALL have port err  output  1  token unrepresentable (underflow or >16-bit operand).

Function
REQ-011 SHALL compute c = ((r*r - a)^2 - b)^2, the exact inverse of c -> isqrt(a + isqrt(b + isqrt(c))).
REQ-012 SHALL contain exactly 3 squarer pipelines: 16-bit in, 32-bit out, MUL_STAGES latency, valid and 1-bit err tag travel with data.
REQ-013 SHALL feed squarer0 directly: x = r, vld = arg_vld, tag = 0.
REQ-014 SHALL push a into FIFO_A and b into FIFO_B on every arg_vld cycle; FIFO_A depth >= MUL_STAGES+1, FIFO_B depth >= 2*MUL_STAGES+2.
REQ-015 SHALL pop FIFO_A when squarer0 output valid; register d0 = s0 - a one cycle later as squarer1 input with valid.
REQ-016 SHALL pop FIFO_B when squarer1 output valid; register d1 = s1 - b one cycle later as squarer2 input with valid.
REQ-017 SHALL use no shift registers for a/b alignment; FIFOs only.
REQ-018 SHALL set token err if subtrahend > minuend (32-bit unsigned compare) at either subtract stage.
REQ-019 SHALL set token err if difference > 0xFFFF at either subtract stage; squarer then gets 0.
REQ-020 SHALL propagate err sticky with its token; err tokens still pop FIFOs so alignment is preserved.
REQ-021 SHALL drive res = squarer2 output when err=0, res = 0 when err=1.
REQ-022 SHALL have fixed latency 3*MUL_STAGES+2 cycles (14 at default) from arg_vld to res_vld.
REQ-023 SHALL accept one token per cycle indefinitely; output pattern equals input arg_vld pattern delayed by latency.
REQ-024 SHALL keep res/err undefined-free: hold previous value when res_vld=0, never X after reset.
REQ-025 SHALL never push a full or pop an empty FIFO under legal stimulus; FIFO full/empty not exported.
REQ-026 SHALL treat arithmetic unsigned, no wrap: all sums/differences checked per REQ-018/019.

Reset
REQ-027 SHALL on rst clear all valid bits, FIFO pointers/counters, err tags; res_vld=0, res=0, err=0.
REQ-028 SHALL on rst mid-operation discard all in-flight tokens; no res_vld for tokens accepted before rst.
REQ-029 SHALL accept arg_vld the first clock after rst deasserts.

Verification
REQ-030 SHALL cover single token: r=5, a=9, b=7 -> after 14 cycles res_vld=1, res=62001, err=0.
REQ-031 SHALL cover underflow: r=2, a=5, b=0 -> res_vld after 14 cycles, res=0, err=1.
REQ-032 SHALL cover width overflow: r=0xFFFF, a=0, b=0 -> d0=0xFFFE0001 > 0xFFFF, res=0, err=1.
REQ-033 SHALL cover 40 back-to-back random tokens mixing valid/err cases -> 40 consecutive res_vld pulses, each matching a reference model of REQ-011/018/019 in order.
REQ-034 SHALL cover gapped input arg_vld = 1,0,1,1,0,1 -> res_vld identical pattern delayed 14 cycles, values in order.
REQ-035 SHALL cover rst asserted with 6 tokens in flight -> no res_vld afterward; new token r=5,a=9,b=7 after rst gives res=62001 at latency 14.

Source files
------------

// File: rtl/formula_2_inverse_pipe_using_fifos.sv
// Inverse of c -> isqrt(a + isqrt(b + isqrt(c))): c = ((r*r - a)^2 - b)^2.
// Three squarer pipelines, with a/b realigned to their subtract stages through FIFOs.

module formula_2_squarer #(
    parameter int unsigned STAGES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vld_i,
    input  logic [15:0] x_i,
    input  logic        err_i,
    output logic        vld_o,
    output logic [31:0] p_o,
    output logic        err_o
);
    logic        vld_q [STAGES];
    logic [31:0] p_q   [STAGES];
    logic        err_q [STAGES];

    // Data stages load only with a valid token, so the last stage holds between tokens.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                vld_q[i] <= 1'b0;
                p_q[i]   <= '0;
                err_q[i] <= 1'b0;
            end
        end else begin
            vld_q[0] <= vld_i;
            if (vld_i) begin
                p_q[0]   <= 32'(x_i) * 32'(x_i);
                err_q[0] <= err_i;
            end
            for (int i = 1; i < int'(STAGES); i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    p_q[i]   <= p_q[i-1];
                    err_q[i] <= err_q[i-1];
                end
            end
        end
    end

    assign vld_o = vld_q[STAGES-1];
    assign p_o   = p_q[STAGES-1];
    assign err_o = err_q[STAGES-1];
endmodule

module formula_2_fifo #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push_i,
    input  logic [31:0] data_i,
    input  logic        pop_i,
    output logic [31:0] data_o
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [31:0]   mem_q [DEPTH];

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (pop_i)  rd_ptr_q <= next_ptr(rd_ptr_q);
        end
    end

    // NOTE: storage is not reset; the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o = mem_q[rd_ptr_q];
endmodule

module formula_2_inverse_pipe_using_fifos #(
    parameter int unsigned MUL_STAGES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        arg_vld,
    input  logic [15:0] r,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        res_vld,
    output logic [31:0] res,
    output logic        err
);
    logic        s0_vld, s1_vld, s2_vld;
    logic [31:0] s0_p, s1_p, s2_p;
    logic        s0_err, s1_err, s2_err;
    logic [31:0] fa_head, fb_head;
    logic [31:0] sub0, sub1;

    logic        d0_vld_q, d0_err_q, d0_err_d;
    logic [15:0] d0_q, d0_d;
    logic        d1_vld_q, d1_err_q, d1_err_d;
    logic [15:0] d1_q, d1_d;

    formula_2_squarer #(.STAGES(MUL_STAGES)) u_sq0 (
        .clk(clk), .rst(rst), .vld_i(arg_vld), .x_i(r), .err_i(1'b0),
        .vld_o(s0_vld), .p_o(s0_p), .err_o(s0_err)
    );

    formula_2_fifo #(.DEPTH(MUL_STAGES + 1)) u_fifo_a (
        .clk(clk), .rst(rst), .push_i(arg_vld), .data_i(a), .pop_i(s0_vld), .data_o(fa_head)
    );

    formula_2_fifo #(.DEPTH(2 * MUL_STAGES + 2)) u_fifo_b (
        .clk(clk), .rst(rst), .push_i(arg_vld), .data_i(b), .pop_i(s1_vld), .data_o(fb_head)
    );

    // An underflowing or over-wide difference marks the token and feeds 0 downstream.
    always_comb begin
        // NOTE: every comb output gets a value on all paths, so no latch is inferred.
        sub0     = s0_p - fa_head;
        d0_err_d = s0_err | (fa_head > s0_p) | (sub0 > 32'h0000_FFFF);
        d0_d     = d0_err_d ? 16'h0 : sub0[15:0];
        sub1     = s1_p - fb_head;
        d1_err_d = s1_err | (fb_head > s1_p) | (sub1 > 32'h0000_FFFF);
        d1_d     = d1_err_d ? 16'h0 : sub1[15:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d0_vld_q <= 1'b0;
            d0_q     <= '0;
            d0_err_q <= 1'b0;
            d1_vld_q <= 1'b0;
            d1_q     <= '0;
            d1_err_q <= 1'b0;
        end else begin
            d0_vld_q <= s0_vld;
            d1_vld_q <= s1_vld;
            if (s0_vld) begin
                d0_q     <= d0_d;
                d0_err_q <= d0_err_d;
            end
            if (s1_vld) begin
                d1_q     <= d1_d;
                d1_err_q <= d1_err_d;
            end
        end
    end

    formula_2_squarer #(.STAGES(MUL_STAGES)) u_sq1 (
        .clk(clk), .rst(rst), .vld_i(d0_vld_q), .x_i(d0_q), .err_i(d0_err_q),
        .vld_o(s1_vld), .p_o(s1_p), .err_o(s1_err)
    );

    formula_2_squarer #(.STAGES(MUL_STAGES)) u_sq2 (
        .clk(clk), .rst(rst), .vld_i(d1_vld_q), .x_i(d1_q), .err_i(d1_err_q),
        .vld_o(s2_vld), .p_o(s2_p), .err_o(s2_err)
    );

    assign res_vld = s2_vld;
    assign res     = s2_err ? 32'h0 : s2_p;
    assign err     = s2_err;
endmodule

// File: tb/tb_formula_2_inverse_pipe_using_fifos.sv
// Random and directed tokens against an arithmetic model of c = ((r*r - a)^2 - b)^2,
// with a per-cycle scoreboard checking output timing, values and order.

module tb_formula_2_inverse_pipe_using_fifos;
    localparam int LAT = 14;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        arg_vld = 1'b0;
    logic [15:0] r = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        res_vld;
    logic [31:0] res;
    logic        err;

    formula_2_inverse_pipe_using_fifos #(.MUL_STAGES(4)) dut (
        .clk(clk), .rst(rst), .arg_vld(arg_vld), .r(r), .a(a), .b(b),
        .res_vld(res_vld), .res(res), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] res;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Any unrepresentable intermediate makes the whole token an error with res = 0.
    function automatic exp_t model(input logic [15:0] rr, input logic [31:0] aa, input logic [31:0] bb);
        exp_t   e;
        longint s, d;
        e.due = 0;
        e.res = 0;
        e.err = 1'b1;
        s = longint'(rr) * longint'(rr);
        d = s - longint'(aa);
        if (d < 0 || d > 65535) return e;
        s = d * d;
        d = s - longint'(bb);
        if (d < 0 || d > 65535) return e;
        e.res = 32'(d * d);
        e.err = 1'b0;
        return e;
    endfunction

    task automatic send(input bit v, input logic [15:0] rr, input logic [31:0] aa, input logic [31:0] bb);
        exp_t e;
        @(negedge clk);
        rst     = 1'b0;
        arg_vld = v;
        r       = rr;
        a       = aa;
        b       = bb;
        if (v) begin
            e     = model(rr, aa, bb);
            e.due = cyc + LAT;
            q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(1'b0, '0, '0, '0);
    endtask

    // Random token: two thirds stay representable, the rest use free a/b.
    task automatic send_random();
        longint s, d, lim;
        logic [15:0] rr;
        logic [31:0] aa, bb;
        rr = 16'($urandom_range(0, 1000));
        if ($urandom_range(0, 2) != 0) begin
            s   = longint'(rr) * longint'(rr);
            lim = (s < 300) ? s : 300;
            aa  = 32'(s - longint'($urandom_range(0, 32'(lim))));
            d   = s - longint'(aa);
            s   = d * d;
            lim = (s < 65535) ? s : 65535;
            bb  = 32'(s - longint'($urandom_range(0, 32'(lim))));
        end else begin
            aa = $urandom();
            bb = $urandom_range(0, 70000);
        end
        send(1'b1, rr, aa, bb);
    endtask

    always @(negedge clk) begin
        bit exp_vld;
        if (!rst) begin
            exp_vld = (q.size() > 0) && (q[0].due == cyc);
            check("res_vld", 64'(res_vld), 64'(exp_vld));
            if (exp_vld) begin
                if (res_vld) begin
                    check("res", 64'(res), 64'(q[0].res));
                    check("err", 64'(err), 64'(q[0].err));
                end
                void'(q.pop_front());
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset res_vld", 64'(res_vld), 64'd0);
        check("reset res", 64'(res), 64'd0);
        check("reset err", 64'(err), 64'd0);

        send(1'b1, 16'd5, 32'd9, 32'd7);
        check("model single", 64'(q[0].res), 64'd62001);
        idle(LAT + 2);
        check("hold res", 64'(res), 64'd62001);
        send(1'b1, 16'd2, 32'd5, 32'd0);
        idle(LAT + 2);
        send(1'b1, 16'hFFFF, 32'd0, 32'd0);
        idle(LAT + 2);

        for (int i = 0; i < 40; i++) send_random();
        idle(LAT + 2);

        send(1'b1, 16'd5, 32'd9, 32'd7);
        send(1'b0, '0, '0, '0);
        send(1'b1, 16'd10, 32'd40, 32'd3000);
        send(1'b1, 16'd3, 32'd10, 32'd0);
        send(1'b0, '0, '0, '0);
        send(1'b1, 16'd20, 32'd300, 32'd9000);
        idle(LAT + 2);

        for (int i = 0; i < 6; i++) send_random();
        @(negedge clk);
        rst     = 1'b1;
        arg_vld = 1'b0;
        q.delete();
        @(negedge clk);
        check("rst res_vld", 64'(res_vld), 64'd0);
        check("rst res", 64'(res), 64'd0);
        check("rst err", 64'(err), 64'd0);
        send(1'b1, 16'd5, 32'd9, 32'd7);
        idle(LAT + 6);

        for (int i = 0; i < 100 && q.size() > 0; i++) @(negedge clk);
        check("drain", 64'(q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
